// File: rtl/m_axi_read.sv
// AXI4-Lite read master that reads or polls the AXI DMA MM2S/S2MM status registers.
// Optional handshake watchdog is enabled by defining M_AXI_READ_TIMEOUT_EN.
module m_axi_read #(
    parameter int GLOB_ADDR_WIDTH = 32,
    parameter int GLOB_DATA_WIDTH = 32,
    parameter int DMA_POLL_TASK_CNT = 2,
    parameter int POLL_CNT_WIDTH = 16,
    parameter logic [POLL_CNT_WIDTH-1:0] POLL_MAX = {POLL_CNT_WIDTH{1'b1}},
    parameter int POLL_GAP = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                         clk,
    input  logic                         reset,
    output logic [GLOB_ADDR_WIDTH-1:0]   M_AXI_ARADDR,
    output logic                         M_AXI_ARVALID,
    input  logic                         M_AXI_ARREADY,
    input  logic [GLOB_DATA_WIDTH-1:0]   M_AXI_RDATA,
    input  logic [1:0]                   M_AXI_RRESP,
    input  logic                         M_AXI_RVALID,
    output logic                         M_AXI_RREADY,
    input  logic [GLOB_ADDR_WIDTH-1:0]   ext_bank0_out_dmaBaseAddr,
    input  logic [DMA_POLL_TASK_CNT-1:0] slaveReadReq,
    input  logic [GLOB_DATA_WIDTH-1:0]   slavePollMask,
    output logic [DMA_POLL_TASK_CNT-1:0] slaveReadFin,
    output logic [GLOB_DATA_WIDTH-1:0]   slaveReadData,
    output logic [1:0]                   slaveReadErr,
    output logic [POLL_CNT_WIDTH-1:0]    slavePollCnt
);
    localparam logic [GLOB_ADDR_WIDTH-1:0] MM2S_OFS = GLOB_ADDR_WIDTH'(32'h0000_0004);
    localparam logic [GLOB_ADDR_WIDTH-1:0] S2MM_OFS = GLOB_ADDR_WIDTH'(32'h0000_0034);
    localparam logic [31:0] GAP_LIM = 32'(POLL_GAP);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_RADDR  = 3'd1,
        S_RDATA  = 3'd2,
        S_CHECK  = 3'd3,
        S_GAP    = 3'd4,
        S_UNLOCK = 3'd5
    } state_t;

    state_t                       state_r;
    logic [DMA_POLL_TASK_CNT-1:0] served_r;
    logic [GLOB_DATA_WIDTH-1:0]   mask_r;
    logic [1:0]                   rresp_r;
    logic [31:0]                  gap_cnt_r;
    logic [DMA_POLL_TASK_CNT-1:0] lowest_req_s;
    logic                         gap_done_s;

    // Isolating the lowest set bit gives lowest-index-wins arbitration.
    assign lowest_req_s = slaveReadReq & (~slaveReadReq + DMA_POLL_TASK_CNT'(1));
    assign gap_done_s   = ((gap_cnt_r + 32'd1) >= GAP_LIM);

`ifdef M_AXI_READ_TIMEOUT_EN
    localparam logic [31:0] WD_LIM = 32'(TIMEOUT_CYCLES - 1);
    logic [31:0] wd_cnt_r;
    logic        wd_fire_s;

    assign wd_fire_s = (wd_cnt_r == WD_LIM);

    // Watchdog: consecutive RADDR/RDATA cycles without the pending handshake.
    always_ff @(posedge clk) begin
        if (reset) begin
            wd_cnt_r <= 32'd0;
        end else if ((state_r == S_RADDR && !M_AXI_ARREADY) ||
                     (state_r == S_RDATA && !M_AXI_RVALID)) begin
            wd_cnt_r <= wd_fire_s ? 32'd0 : wd_cnt_r + 32'd1;
        end else begin
            wd_cnt_r <= 32'd0;
        end
    end
`endif

    // Main request FSM with registered AXI and slave-side outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r       <= S_IDLE;
            served_r      <= {DMA_POLL_TASK_CNT{1'b0}};
            mask_r        <= {GLOB_DATA_WIDTH{1'b0}};
            rresp_r       <= 2'b00;
            gap_cnt_r     <= 32'd0;
            M_AXI_ARADDR  <= {GLOB_ADDR_WIDTH{1'b0}};
            M_AXI_ARVALID <= 1'b0;
            M_AXI_RREADY  <= 1'b0;
            slaveReadFin  <= {DMA_POLL_TASK_CNT{1'b0}};
            slaveReadData <= {GLOB_DATA_WIDTH{1'b0}};
            slaveReadErr  <= 2'b00;
            slavePollCnt  <= {POLL_CNT_WIDTH{1'b0}};
        end else begin
            slaveReadFin <= {DMA_POLL_TASK_CNT{1'b0}};
            case (state_r)
                S_IDLE: begin
                    if (slaveReadReq != {DMA_POLL_TASK_CNT{1'b0}}) begin
                        served_r      <= lowest_req_s;
                        mask_r        <= slavePollMask;
                        M_AXI_ARADDR  <= ext_bank0_out_dmaBaseAddr +
                                         (lowest_req_s[0] ? MM2S_OFS : S2MM_OFS);
                        slavePollCnt  <= {POLL_CNT_WIDTH{1'b0}};
                        M_AXI_ARVALID <= 1'b1;
                        state_r       <= S_RADDR;
                    end
                end
                S_RADDR: begin
                    if (M_AXI_ARREADY) begin
                        M_AXI_ARVALID <= 1'b0;
                        M_AXI_RREADY  <= 1'b1;
                        if (slavePollCnt != POLL_MAX) begin
                            slavePollCnt <= slavePollCnt + POLL_CNT_WIDTH'(1);
                        end
                        state_r <= S_RDATA;
                    end
`ifdef M_AXI_READ_TIMEOUT_EN
                    else if (wd_fire_s) begin
                        M_AXI_ARVALID <= 1'b0;
                        slaveReadFin  <= served_r;
                        slaveReadErr  <= 2'b11;
                        state_r       <= S_UNLOCK;
                    end
`endif
                end
                S_RDATA: begin
                    if (M_AXI_RVALID) begin
                        M_AXI_RREADY  <= 1'b0;
                        slaveReadData <= M_AXI_RDATA;
                        rresp_r       <= M_AXI_RRESP;
                        state_r       <= S_CHECK;
                    end
`ifdef M_AXI_READ_TIMEOUT_EN
                    else if (wd_fire_s) begin
                        M_AXI_RREADY <= 1'b0;
                        slaveReadFin <= served_r;
                        slaveReadErr <= 2'b11;
                        state_r      <= S_UNLOCK;
                    end
`endif
                end
                S_CHECK: begin
                    // Bus error beats completion, completion beats exhaustion.
                    if (rresp_r != 2'b00) begin
                        slaveReadFin <= served_r;
                        slaveReadErr <= 2'b01;
                        state_r      <= S_UNLOCK;
                    end else if ((mask_r == {GLOB_DATA_WIDTH{1'b0}}) ||
                                 ((slaveReadData & mask_r) != {GLOB_DATA_WIDTH{1'b0}})) begin
                        slaveReadFin <= served_r;
                        slaveReadErr <= 2'b00;
                        state_r      <= S_UNLOCK;
                    end else if (slavePollCnt == POLL_MAX) begin
                        slaveReadFin <= served_r;
                        slaveReadErr <= 2'b10;
                        state_r      <= S_UNLOCK;
                    end else begin
                        gap_cnt_r <= 32'd0;
                        state_r   <= S_GAP;
                    end
                end
                S_GAP: begin
                    if (gap_done_s) begin
                        M_AXI_ARVALID <= 1'b1;
                        state_r       <= S_RADDR;
                    end else begin
                        gap_cnt_r <= gap_cnt_r + 32'd1;
                    end
                end
                S_UNLOCK: begin
                    state_r <= S_IDLE;
                end
                default: begin
                    M_AXI_ARVALID <= 1'b0;
                    M_AXI_RREADY  <= 1'b0;
                    state_r       <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_m_axi_read.sv
// Randomized self-checking bench for m_axi_read with a queue-driven AXI-Lite slave
// and a read-sequence reference model (POLL_MAX=3, POLL_GAP=4, TIMEOUT_CYCLES=8).
module tb_m_axi_read;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int NT = 2;
    localparam int CW = 16;
    localparam int GAP = 4;
    localparam logic [15:0] PMAX = 16'd3;
    localparam int TMO = 8;

    logic clk = 1'b0;
    logic reset;
    logic [AW-1:0] araddr;
    logic arvalid, arready;
    logic [DW-1:0] rdata;
    logic [1:0] rresp;
    logic rvalid, rready;
    logic [AW-1:0] base;
    logic [NT-1:0] req;
    logic [DW-1:0] mask;
    logic [NT-1:0] fin;
    logic [DW-1:0] data;
    logic [1:0] err;
    logic [CW-1:0] cnt;

    int checks = 0;
    int errors = 0;

    // Slave state and transaction logs.
    bit ar_block, r_hold, rnd_mode, chk_proto, r_pend;
    int r_wait, cyc, proto_viol;
    logic [33:0] rsp_q[$];
    logic [31:0] ar_log[$];
    int ar_cyc[$];
    int r_cyc[$];

    always #5 clk = ~clk;

    m_axi_read #(
        .GLOB_ADDR_WIDTH(AW), .GLOB_DATA_WIDTH(DW), .DMA_POLL_TASK_CNT(NT),
        .POLL_CNT_WIDTH(CW), .POLL_MAX(PMAX), .POLL_GAP(GAP), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk(clk), .reset(reset),
        .M_AXI_ARADDR(araddr), .M_AXI_ARVALID(arvalid), .M_AXI_ARREADY(arready),
        .M_AXI_RDATA(rdata), .M_AXI_RRESP(rresp), .M_AXI_RVALID(rvalid), .M_AXI_RREADY(rready),
        .ext_bank0_out_dmaBaseAddr(base), .slaveReadReq(req), .slavePollMask(mask),
        .slaveReadFin(fin), .slaveReadData(data), .slaveReadErr(err), .slavePollCnt(cnt)
    );

    // AXI-Lite slave: returns queued {resp,data} beats, logs AR addresses and handshake cycles.
    initial begin
        logic ar_hs, r_hs, prev_arv, prev_hs;
        logic [31:0] addr_now, prev_addr;
        arready = 1'b0; rvalid = 1'b0; rdata = 32'd0; rresp = 2'b00;
        r_pend = 1'b0; r_wait = 0; cyc = 0; proto_viol = 0;
        prev_arv = 1'b0; prev_hs = 1'b0; prev_addr = 32'd0;
        forever begin
            @(posedge clk);
            cyc++;
            ar_hs = arvalid && arready;
            r_hs = rvalid && rready;
            addr_now = araddr;
            if (chk_proto && prev_arv && !prev_hs && (arvalid !== 1'b1 || araddr !== prev_addr))
                proto_viol++;
            prev_arv = arvalid; prev_hs = ar_hs; prev_addr = araddr;
            #1;
            if (ar_hs) begin
                ar_log.push_back(addr_now);
                ar_cyc.push_back(cyc);
                r_pend = 1'b1;
                r_wait = rnd_mode ? int'($urandom_range(0, 3)) : 0;
            end
            if (r_hs) begin
                rvalid = 1'b0;
                r_cyc.push_back(cyc);
            end
            if (r_pend && !rvalid && !r_hold) begin
                if (r_wait == 0) begin
                    {rresp, rdata} = (rsp_q.size() > 0) ? rsp_q.pop_front() : 34'd0;
                    rvalid = 1'b1;
                    r_pend = 1'b0;
                end else begin
                    r_wait--;
                end
            end
            arready = !ar_block && (!rnd_mode || ($urandom_range(0, 2) == 0));
        end
    end

    // Reference: walk the beats the way the spec's rules describe a request.
    function automatic void model(input logic [31:0] m, input logic [33:0] rs [0:2],
                                  output logic [1:0] e, output logic [15:0] n, output logic [31:0] d);
        e = 2'b00; n = 16'd0; d = 32'd0;
        for (int i = 0; i < 3; i++) begin
            n = n + 16'd1;
            d = rs[i][31:0];
            if (rs[i][33:32] != 2'b00) begin e = 2'b01; return; end
            if (m == 32'd0 || (d & m) != 32'd0) begin e = 2'b00; return; end
            if (n == PMAX) begin e = 2'b10; return; end
        end
    endfunction

    function automatic logic [31:0] exp_addr(input logic [31:0] b, input logic [1:0] r);
        return r[0] ? (b + 32'h0000_0004) : (b + 32'h0000_0034);
    endfunction

    task automatic clear_logs();
        rsp_q.delete(); ar_log.delete(); ar_cyc.delete(); r_cyc.delete();
    endtask

    task automatic wait_fin(input int budget, output logic [1:0] f, output logic [1:0] e,
                            output logic [31:0] d, output logic [15:0] pc, output int lat);
        f = 2'b00; e = 2'b00; d = 32'd0; pc = 16'd0; lat = 0;
        for (int c = 1; c <= budget; c++) begin
            @(negedge clk);
            if (fin != 2'b00) begin
                f = fin; e = err; d = data; pc = cnt; lat = c;
                break;
            end
        end
        if (lat == 0) req = 2'b00;
        else req = req & ~f;
    endtask

    task automatic do_request(input logic [1:0] r, input logic [31:0] m, input int budget,
                              output logic [1:0] f, output logic [1:0] e, output logic [31:0] d,
                              output logic [15:0] pc, output int lat);
        @(posedge clk); #1;
        req = r; mask = m;
        wait_fin(budget, f, e, d, pc, lat);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if ({arvalid, rready, fin, err} !== 6'd0) begin errors++;
            $display("FAIL reset_ctrl got arvalid=%b rready=%b fin=%b err=%b want 0", arvalid, rready, fin, err); end
        checks++; if (araddr !== 32'd0 || data !== 32'd0 || cnt !== 16'd0) begin errors++;
            $display("FAIL reset_regs got addr=%h data=%h cnt=%0d want 0", araddr, data, cnt); end
        reset = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_single_read();
        logic [1:0] f, e; logic [31:0] d; logic [15:0] pc; int lat;
        logic [33:0] rs [0:2]; logic [1:0] xe; logic [15:0] xn; logic [31:0] xd;
        clear_logs(); rnd_mode = 1'b0; chk_proto = 1'b1;
        base = 32'h4040_0000;
        rs[0] = {2'b00, 32'h0001_0001}; rs[1] = 34'd0; rs[2] = 34'd0;
        model(32'd0, rs, xe, xn, xd);
        rsp_q.push_back(rs[0]);
        do_request(2'b01, 32'd0, 100, f, e, d, pc, lat);
        checks++; if (f !== 2'b01) begin errors++; $display("FAIL single_fin got %b want 01", f); end
        // Req seen in cycle 1, then RADDR, RDATA, CHECK; Fin is high in cycle 5 (UNLOCK).
        checks++; if (lat != 5) begin errors++; $display("FAIL single_latency got %0d want 5", lat); end
        checks++; if (d !== xd || e !== xe || pc !== xn) begin errors++;
            $display("FAIL single_result got data=%h err=%b cnt=%0d want %h %b %0d", d, e, pc, xd, xe, xn); end
        checks++; if (ar_log.size() != 1 || ar_log[0] !== 32'h4040_0004) begin errors++;
            $display("FAIL single_addr got n=%0d addr=%h want 1 40400004", ar_log.size(),
                     (ar_log.size() > 0) ? ar_log[0] : 32'hx); end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_poll();
        logic [1:0] f, e; logic [31:0] d; logic [15:0] pc; int lat; int bad;
        logic [33:0] rs [0:2]; logic [1:0] xe; logic [15:0] xn; logic [31:0] xd;
        clear_logs();
        rs[0] = 34'd0; rs[1] = 34'd0; rs[2] = {2'b00, 32'h0000_0002};
        model(32'h2, rs, xe, xn, xd);
        for (int i = 0; i < 3; i++) rsp_q.push_back(rs[i]);
        do_request(2'b10, 32'h2, 200, f, e, d, pc, lat);
        checks++; if (f !== 2'b10) begin errors++; $display("FAIL poll_fin got %b want 10", f); end
        checks++; if (d !== xd || e !== xe || pc !== xn || pc !== 16'd3) begin errors++;
            $display("FAIL poll_result got data=%h err=%b cnt=%0d want %h %b %0d", d, e, pc, xd, xe, xn); end
        bad = 0;
        foreach (ar_log[i]) if (ar_log[i] !== 32'h4040_0034) bad++;
        checks++; if (ar_log.size() != 3 || bad != 0) begin errors++;
            $display("FAIL poll_addr got n=%0d badaddr=%0d want 3 0", ar_log.size(), bad); end
        // Between an R handshake and the next AR: one CHECK cycle plus POLL_GAP gap cycles.
        bad = 0;
        for (int i = 0; i < 2; i++)
            if (i + 1 < ar_cyc.size() && i < r_cyc.size() && (ar_cyc[i+1] - r_cyc[i] - 1) != GAP + 1) bad++;
        checks++; if (bad != 0 || r_cyc.size() != 3) begin errors++;
            $display("FAIL poll_gap got bad_gaps=%0d rbeats=%0d want 0 3", bad, r_cyc.size()); end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_error();
        logic [1:0] f, e; logic [31:0] d; logic [15:0] pc; int lat;
        clear_logs();
        rsp_q.push_back({2'b10, 32'h0000_0002});
        do_request(2'b10, 32'h2, 100, f, e, d, pc, lat);
        checks++; if (f !== 2'b10 || e !== 2'b01) begin errors++; $display("FAIL error_resp got fin=%b err=%b want 10 01", f, e); end
        checks++; if (pc !== 16'd1 || ar_log.size() != 1) begin errors++;
            $display("FAIL error_noretry got cnt=%0d reads=%0d want 1 1", pc, ar_log.size()); end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_exhaustion();
        logic [1:0] f, e; logic [31:0] d; logic [15:0] pc; int lat;
        clear_logs();
        for (int i = 0; i < 5; i++) rsp_q.push_back(34'd0);
        do_request(2'b01, 32'h1, 200, f, e, d, pc, lat);
        checks++; if (f !== 2'b01 || e !== 2'b10) begin errors++; $display("FAIL exhaust_err got fin=%b err=%b want 01 10", f, e); end
        checks++; if (pc !== 16'd3 || ar_log.size() != 3) begin errors++;
            $display("FAIL exhaust_count got cnt=%0d reads=%0d want 3 3", pc, ar_log.size()); end
        repeat (4) @(negedge clk);
    endtask

    task automatic test_arbitration();
        logic [1:0] f, e; logic [31:0] d; logic [15:0] pc; int lat;
        clear_logs();
        base = 32'hFFFF_FFE0;
        rsp_q.push_back({2'b00, 32'hA5A5_0001});
        rsp_q.push_back({2'b00, 32'h5A5A_0002});
        do_request(2'b11, 32'd0, 100, f, e, d, pc, lat);
        checks++; if (f !== 2'b01 || d !== 32'hA5A5_0001) begin errors++;
            $display("FAIL arb_first got fin=%b data=%h want 01 a5a50001", f, d); end
        wait_fin(100, f, e, d, pc, lat);
        checks++; if (f !== 2'b10 || d !== 32'h5A5A_0002 || e !== 2'b00) begin errors++;
            $display("FAIL arb_second got fin=%b data=%h err=%b want 10 5a5a0002 00", f, d, e); end
        // Second address wraps modulo 2^32.
        checks++; if (ar_log.size() != 2 || ar_log[0] !== 32'hFFFF_FFE4 || ar_log[1] !== 32'h0000_0014) begin errors++;
            $display("FAIL arb_addr got n=%0d want ffffffe4 then 00000014", ar_log.size()); end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset_mid();
        int seen;
        clear_logs(); chk_proto = 1'b0; r_hold = 1'b1;
        @(posedge clk); #1;
        req = 2'b01; mask = 32'd0;
        seen = 0;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            if (rready === 1'b1) begin seen = 1; break; end
        end
        checks++; if (seen != 1) begin errors++; $display("FAIL rstmid_reach got rready_seen=%0d want 1", seen); end
        reset = 1'b1; req = 2'b00;
        @(negedge clk);
        checks++; if ({arvalid, rready, fin, err} !== 6'd0 || araddr !== 32'd0 || data !== 32'd0 || cnt !== 16'd0) begin errors++;
            $display("FAIL rstmid_outputs got arv=%b rr=%b fin=%b err=%b addr=%h data=%h cnt=%0d want 0",
                     arvalid, rready, fin, err, araddr, data, cnt); end
        reset = 1'b0; r_hold = 1'b0; r_pend = 1'b0;
        seen = 0;
        repeat (4) begin @(negedge clk); if (arvalid !== 1'b0 || rready !== 1'b0) seen++; end
        checks++; if (seen != 0) begin errors++; $display("FAIL rstmid_idle got busy_cycles=%0d want 0", seen); end
        clear_logs(); chk_proto = 1'b1;
    endtask

    task automatic test_random();
        logic [1:0] f, e, r; logic [31:0] d, m; logic [15:0] pc; int lat, bad;
        logic [33:0] rs [0:2]; logic [1:0] xe; logic [15:0] xn; logic [31:0] xd;
        rnd_mode = 1'b1; proto_viol = 0;
        for (int it = 0; it < 24; it++) begin
            clear_logs();
            base = $urandom;
            r = 2'($urandom_range(1, 3));
            m = ($urandom_range(0, 3) == 0) ? 32'd0 : (32'd1 << $urandom_range(0, 31));
            for (int i = 0; i < 3; i++) begin
                rs[i][31:0] = ($urandom_range(0, 2) == 0) ? (m | 32'($urandom)) : (32'($urandom) & ~m);
                rs[i][33:32] = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
                rsp_q.push_back(rs[i]);
            end
            model(m, rs, xe, xn, xd);
            do_request(r, m, 300, f, e, d, pc, lat);
            bad = 0;
            foreach (ar_log[i]) if (ar_log[i] !== exp_addr(base, r)) bad++;
            checks++; if (f !== (r[0] ? 2'b01 : 2'b10) || e !== xe || d !== xd || pc !== xn) begin errors++;
                $display("FAIL rand_result it=%0d got fin=%b err=%b data=%h cnt=%0d want %b %b %h %0d",
                         it, f, e, d, pc, (r[0] ? 2'b01 : 2'b10), xe, xd, xn); end
            checks++; if (ar_log.size() != int'(xn) || bad != 0) begin errors++;
                $display("FAIL rand_reads it=%0d got n=%0d badaddr=%0d want %0d 0", it, ar_log.size(), bad, xn); end
            req = 2'b00;
            repeat (2) @(negedge clk);
        end
        checks++; if (proto_viol != 0) begin errors++; $display("FAIL rand_arvalid_stable got %0d violations want 0", proto_viol); end
        rnd_mode = 1'b0; clear_logs();
    endtask

`ifdef M_AXI_READ_TIMEOUT_EN
    task automatic test_timeout();
        int hi, lat; logic [1:0] f, e; logic [15:0] pc;
        clear_logs(); chk_proto = 1'b0; ar_block = 1'b1;
        @(negedge clk);
        @(posedge clk); #1;
        req = 2'b01; mask = 32'd0;
        hi = 0; lat = 0; f = 2'b00; e = 2'b00; pc = 16'd0;
        for (int c = 1; c <= 60; c++) begin
            @(negedge clk);
            if (arvalid === 1'b1) hi++;
            if (fin != 2'b00) begin f = fin; e = err; pc = cnt; lat = c; break; end
        end
        req = 2'b00;
        checks++; if (f !== 2'b01 || e !== 2'b11) begin errors++; $display("FAIL timeout_err got fin=%b err=%b want 01 11", f, e); end
        checks++; if (hi != TMO || arvalid !== 1'b0 || pc !== 16'd0) begin errors++;
            $display("FAIL timeout_arvalid got high_cycles=%0d arvalid=%b cnt=%0d want %0d 0 0", hi, arvalid, pc, TMO); end
        ar_block = 1'b0;
        repeat (3) @(negedge clk);
    endtask
`endif

    initial begin
        reset = 1'b1; req = 2'b00; mask = 32'd0; base = 32'd0;
        ar_block = 1'b0; r_hold = 1'b0; rnd_mode = 1'b0; chk_proto = 1'b0;
        test_reset();
        test_single_read();
        test_poll();
        test_error();
        test_exhaustion();
        test_arbitration();
        test_reset_mid();
        test_random();
`ifdef M_AXI_READ_TIMEOUT_EN
        test_timeout();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
